// File: rtl/dmem_resp_pkg.sv
// rtl/dmem_resp_pkg.sv - load sub-type codes and lane helpers for the data-memory responder
package dmem_resp_pkg;

    localparam logic [3:0] L_B  = 4'd0;
    localparam logic [3:0] L_H  = 4'd1;
    localparam logic [3:0] L_W  = 4'd2;
    localparam logic [3:0] L_BU = 4'd4;
    localparam logic [3:0] L_HU = 4'd5;

    localparam int RAM_AW = 30;

    // Enabled byte lanes come from data, the rest from old.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] data,
                                                input logic [3:0]  byte_en);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) res[8*i +: 8] = data[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_resp_if.sv
// rtl/dmem_resp_if.sv - memory-stage RAM request/response bundle
interface dmem_resp_if;
    logic        ram_r_en;
    logic [29:0] ram_r_addr;
    logic [3:0]  ld_sub_type;
    logic [1:0]  ld_offset;
    logic        ram_w_en;
    logic [29:0] ram_w_addr;
    logic [31:0] ram_w_data;
    logic [3:0]  ram_byte_en;
    logic [31:0] ram_r_data;
    logic [31:0] ld_val;
    logic        ld_valid;
    logic        ld_err;
    logic        init_done;

    modport master (
        output ram_r_en, ram_r_addr, ld_sub_type, ld_offset,
               ram_w_en, ram_w_addr, ram_w_data, ram_byte_en,
        input  ram_r_data, ld_val, ld_valid, ld_err, init_done
    );

    modport slave (
        input  ram_r_en, ram_r_addr, ld_sub_type, ld_offset,
               ram_w_en, ram_w_addr, ram_w_data, ram_byte_en,
        output ram_r_data, ld_val, ld_valid, ld_err, init_done
    );
endinterface

// File: rtl/dmem_load_align.sv
// rtl/dmem_load_align.sv - combinational load extract, sign/zero extend and error detect
module dmem_load_align
    import dmem_resp_pkg::*;
(
    input  logic [31:0] word,
    input  logic [3:0]  sub_type,
    input  logic [1:0]  offset,
    input  logic        oob,
    output logic [31:0] val,
    output logic        err
);

    logic [31:0] shifted;

    always_comb begin
        shifted = word >> {offset, 3'b000};
        val     = '0;
        err     = 1'b0;
        case (sub_type)
            L_B:  val = {{24{shifted[7]}}, shifted[7:0]};
            L_BU: val = {24'h0, shifted[7:0]};
            L_H:  begin
                err = offset[0];
                val = {{16{shifted[15]}}, shifted[15:0]};
            end
            L_HU: begin
                err = offset[0];
                val = {16'h0, shifted[15:0]};
            end
            L_W:  begin
                err = (offset != 2'd0);
                val = word;
            end
            default: err = 1'b1;
        endcase
        if (oob) err = 1'b1;
        if (err) val = '0;
    end

endmodule

// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - data-memory responder with clear sequencer; DMEM_RESP_BYPASS_EN forwards same-cycle writes to reads
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    dmem_resp_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic [31:0]         mem [DEPTH];

    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W-1:0]   w_idx;
    logic                r_oob;
    logic                w_hit;
    logic [31:0]         rd_word;
    logic [31:0]         al_val;
    logic                al_err;

    assign r_idx = bus.ram_r_addr[ADDR_W-1:0];
    assign w_idx = bus.ram_w_addr[ADDR_W-1:0];
    assign r_oob = |bus.ram_r_addr[RAM_AW-1:ADDR_W];
    assign w_hit = bus.ram_w_en && !(|bus.ram_w_addr[RAM_AW-1:ADDR_W]);

`ifdef DMEM_RESP_BYPASS_EN
    assign rd_word = (w_hit && (bus.ram_w_addr == bus.ram_r_addr))
                   ? merge_lanes(mem[r_idx], bus.ram_w_data, bus.ram_byte_en)
                   : mem[r_idx];
`else
    // Read-before-write: the array read sees the word before this edge's write.
    assign rd_word = mem[r_idx];
`endif

    dmem_load_align u_align (
        .word     (rd_word),
        .sub_type (bus.ld_sub_type),
        .offset   (bus.ld_offset),
        .oob      (r_oob),
        .val      (al_val),
        .err      (al_err)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_CLEAR) begin
                mem[cnt] <= INIT_VAL;
            end else if (w_hit) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus.ram_byte_en[i]) mem[w_idx][8*i +: 8] <= bus.ram_w_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_CLEAR;
            cnt            <= '0;
            bus.ram_r_data <= '0;
            bus.ld_val     <= '0;
            bus.ld_valid   <= 1'b0;
            bus.ld_err     <= 1'b0;
            bus.init_done  <= 1'b0;
        end else begin
            bus.ld_valid <= 1'b0;
            bus.ld_err   <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == {ADDR_W{1'b1}}) begin
                        state         <= ST_RUN;
                        bus.init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.ram_r_en) begin
                        bus.ram_r_data <= rd_word;
                        bus.ld_val     <= al_val;
                        bus.ld_err     <= al_err;
                        bus.ld_valid   <= 1'b1;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_resp.sv
// tb/tb_dmem_resp.sv - self-checking bench for dmem_resp (honours DMEM_RESP_BYPASS_EN)
module tb_dmem_resp;
    import dmem_resp_pkg::*;

    localparam int          AW    = 4;
    localparam int          DEPTH = 16;
    localparam logic [31:0] IV    = 32'hA5A5A5A5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_resp_if bus ();

    dmem_resp #(.ADDR_W(AW), .INIT_VAL(IV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus.ram_r_en    = 1'b0;
        bus.ram_r_addr  = '0;
        bus.ld_sub_type = '0;
        bus.ld_offset   = '0;
        bus.ram_w_en    = 1'b0;
        bus.ram_w_addr  = '0;
        bus.ram_w_data  = '0;
        bus.ram_byte_en = '0;
    endtask

    task automatic model_fill();
        for (int i = 0; i < DEPTH; i++) model[i] = IV;
    endtask

    // Reference load semantics in plain integer arithmetic.
    function automatic void ref_load(input logic [31:0] w, input int sub, input int off,
                                     input bit oob, output logic [31:0] v, output bit err);
        logic [31:0] b;
        int x;
        b   = w >> (8 * off);
        err = oob;
        x   = 0;
        if (sub == 0 || sub == 4) begin
            x = int'(b & 32'hFF);
            if (sub == 0 && x > 127) x -= 256;
        end else if (sub == 1 || sub == 5) begin
            if (off % 2 != 0) err = 1'b1;
            x = int'(b & 32'hFFFF);
            if (sub == 1 && x > 32767) x -= 65536;
        end else if (sub == 2) begin
            if (off != 0) err = 1'b1;
            x = int'(w);
        end else begin
            err = 1'b1;
        end
        v = err ? 32'h0 : 32'(x);
    endfunction

    task automatic step(input bit r_en, input int r_addr, input int sub, input int off,
                        input bit w_en, input int w_addr, input logic [31:0] w_data,
                        input logic [3:0] be, output logic [31:0] got);
        logic [31:0] exp_raw, exp_val;
        bit          exp_err;
        exp_raw = model[r_addr % DEPTH];
`ifdef DMEM_RESP_BYPASS_EN
        if (w_en && w_addr == r_addr && w_addr < DEPTH)
            for (int i = 0; i < 4; i++) if (be[i]) exp_raw[8*i +: 8] = w_data[8*i +: 8];
`endif
        ref_load(exp_raw, sub, off, r_addr >= DEPTH, exp_val, exp_err);
        bus.ram_r_en    = r_en;
        bus.ram_r_addr  = 30'(r_addr);
        bus.ld_sub_type = 4'(sub);
        bus.ld_offset   = 2'(off);
        bus.ram_w_en    = w_en;
        bus.ram_w_addr  = 30'(w_addr);
        bus.ram_w_data  = w_data;
        bus.ram_byte_en = be;
        @(posedge clk);
        #1;
        if (w_en && w_addr < DEPTH)
            for (int i = 0; i < 4; i++) if (be[i]) model[w_addr][8*i +: 8] = w_data[8*i +: 8];
        chk("ld_valid", 32'(bus.ld_valid), 32'(r_en));
        if (r_en) begin
            chk("ram_r_data", bus.ram_r_data, exp_raw);
            chk("ld_val", bus.ld_val, exp_val);
            chk("ld_err", 32'(bus.ld_err), 32'(exp_err));
        end
        got = bus.ld_val;
        drive_idle();
    endtask

    // Hammers requests at word 7 during clear; none may be serviced.
    task automatic wait_init(input string tag);
        int cyc;
        int bad;
        cyc = 0;
        bad = 0;
        bus.ram_r_en    = 1'b1;
        bus.ram_r_addr  = 30'd7;
        bus.ld_sub_type = L_W;
        bus.ram_w_en    = 1'b1;
        bus.ram_w_addr  = 30'd7;
        bus.ram_w_data  = 32'hDEADBEEF;
        bus.ram_byte_en = 4'hF;
        while (cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.ld_valid !== 1'b0) bad++;
            if (bus.init_done === 1'b1) break;
        end
        drive_idle();
        chk(tag, 32'(cyc), 32'd16);
        chk({tag, "_no_valid"}, 32'(bad), 32'd0);
        model_fill();
    endtask

    logic [31:0] v;
    int          subs [7] = '{0, 1, 2, 4, 5, 3, 7};

    initial begin
        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_init_done", 32'(bus.init_done), 32'd0);
        chk("rst_ld_valid", 32'(bus.ld_valid), 32'd0);
        chk("rst_ld_err", 32'(bus.ld_err), 32'd0);
        chk("rst_ram_r_data", bus.ram_r_data, 32'd0);
        chk("rst_ld_val", bus.ld_val, 32'd0);
        rst = 1'b0;
        wait_init("clear_cycles");

        step(1, 7, L_W, 0, 0, 0, 0, 4'h0, v);
        chk("word7_init", v, 32'hA5A5A5A5);

        step(0, 0, 0, 0, 1, 3, 32'h11223344, 4'b1111, v);
        step(0, 0, 0, 0, 1, 3, 32'h0000AB00, 4'b0010, v);
        step(0, 0, 0, 0, 1, 3, 32'hFFFFFFFF, 4'b0000, v);
        step(1, 3, L_W, 0, 0, 0, 0, 4'h0, v);
        chk("be_merge", v, 32'h1122AB44);

        step(0, 0, 0, 0, 1, 9, 32'h80FF7F01, 4'hF, v);
        step(1, 9, L_B, 1, 0, 0, 0, 4'h0, v);  chk("lb_off1", v, 32'h0000007F);
        step(1, 9, L_B, 2, 0, 0, 0, 4'h0, v);  chk("lb_off2", v, 32'hFFFFFFFF);
        step(1, 9, L_BU, 2, 0, 0, 0, 4'h0, v); chk("lbu_off2", v, 32'h000000FF);
        step(1, 9, L_H, 2, 0, 0, 0, 4'h0, v);  chk("lh_off2", v, 32'hFFFF80FF);
        step(1, 9, L_HU, 2, 0, 0, 0, 4'h0, v); chk("lhu_off2", v, 32'h000080FF);

        step(1, 9, L_H, 1, 0, 0, 0, 4'h0, v);
        chk("err_lh_off1", 32'(bus.ld_err), 32'd1);
        chk("err_lh_off1_val", v, 32'd0);
        step(1, 9, L_W, 2, 0, 0, 0, 4'h0, v);
        chk("err_lw_off2", 32'(bus.ld_err), 32'd1);
        step(1, DEPTH, L_W, 0, 0, 0, 0, 4'h0, v);
        chk("err_oob", 32'(bus.ld_err), 32'd1);
        chk("err_oob_raw", bus.ram_r_data, 32'hA5A5A5A5);
        step(1, 9, 7, 0, 0, 0, 0, 4'h0, v);
        chk("err_sub7", 32'(bus.ld_err), 32'd1);

        step(0, 0, 0, 0, 1, 5, 32'h0, 4'hF, v);
        step(1, 5, L_W, 0, 1, 5, 32'hDEADBEEF, 4'hF, v);
`ifdef DMEM_RESP_BYPASS_EN
        chk("collide_same_cycle", v, 32'hDEADBEEF);
`else
        chk("collide_same_cycle", v, 32'h0);
`endif
        step(1, 5, L_W, 0, 0, 0, 0, 4'h0, v);
        chk("collide_next", v, 32'hDEADBEEF);

        for (int n = 0; n < 400; n++) begin
            int ra, wa;
            ra = int'($urandom_range(0, DEPTH + 1));
            wa = ($urandom_range(0, 3) == 0) ? ra : int'($urandom_range(0, DEPTH + 1));
            step(1'($urandom_range(0, 3) != 0), ra, subs[$urandom_range(0, 6)],
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), wa,
                 32'($urandom), 4'($urandom_range(0, 15)), v);
        end

        step(0, 0, 0, 0, 1, 2, 32'h12345678, 4'hF, v);
        bus.ram_r_en    = 1'b1;
        bus.ram_r_addr  = 30'd2;
        bus.ld_sub_type = L_W;
        rst             = 1'b1;
        @(posedge clk);
        #1;
        chk("midrun_rst_valid", 32'(bus.ld_valid), 32'd0);
        chk("midrun_rst_init_done", 32'(bus.init_done), 32'd0);
        rst = 1'b0;
        drive_idle();
        wait_init("reclear_cycles");
        step(1, 2, L_W, 0, 0, 0, 0, 4'h0, v);
        chk("reclear_word2", v, 32'hA5A5A5A5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
- Data-memory responder at the far end of the memory-stage RAM interface.
- Accepts word-addressed read and write requests with byte enables.
- Returns read data one cycle later, already extracted and sign/zero-extended per load sub-type, ready for writeback.
- After reset, a built-in clear sequencer initialises every word before servicing requests.

Parameters:
- ADDR_W, 10, word-address bits implemented; depth = 2**ADDR_W words.
- INIT_VAL, 32'h0000_0000, value written to every word during the clear sequence.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ram_r_en  in  1  read request this cycle
- ram_r_addr  in  30  read word address
- ld_sub_type  in  4  load sub-type code from the shared defines header
- ld_offset  in  2  byte offset (ex_val[1:0]) of the load
- ram_w_en  in  1  write request this cycle
- ram_w_addr  in  30  write word address
- ram_w_data  in  32  write data, pre-shifted into byte lanes
- ram_byte_en  in  4  per-lane write enable; bit i covers bits [8i+7:8i]
- ram_r_data  out  32  raw word read (registered)
- ld_val  out  32  extracted, extended load value
- ld_valid  out  1  ld_val/ram_r_data valid this cycle
- ld_err  out  1  misaligned, out-of-range or unknown-sub-type load
- init_done  out  1  clear finished; requests are serviced

Behaviour:
- Reset (rst=1 at an edge): state goes to CLEAR, clear counter resets to 0, and outputs are ram_r_data=0, ld_val=0, ld_valid=0, ld_err=0, init_done=0.
- Reset mid-clear or mid-run restarts the clear from word 0. Any pending ld_valid is dropped.
- FSM, CLEAR state:
  - Writes INIT_VAL to word[cnt] each cycle, then cnt++.
  - All requests are ignored: no writes, ld_valid stays 0.
  - At cnt = depth-1 the state moves to RUN. init_done=1 from the next cycle.
  - Total clear time is 2**ADDR_W cycles.
- FSM, RUN state: stays in RUN until rst.
- Write (RUN, ram_w_en=1):
  - At the edge, each lane with ram_byte_en[i]=1 takes ram_w_data lane i; other lanes are unchanged.
  - byte_en=0000 changes nothing.
  - If ram_w_addr[29:ADDR_W] != 0 the write is silently dropped.
- Read (RUN, ram_r_en=1) presented in cycle T:
  - Address, sub-type and offset are registered at the end of T.
  - During T+1: ld_valid=1, with ram_r_data and ld_val valid.
  - ld_valid=0 in any cycle not following a read request.
  - Reads are fully pipelined: back-to-back reads each return after 1 cycle.
- Extraction, using byte b = word >> (8*offset):
  - L_B: sign-extend b[7:0].
  - L_BU: zero-extend b[7:0].
  - L_H: offset must be 0 or 2; sign-extend b[15:0].
  - L_HU: same offsets as L_H; zero-extend.
  - L_W: offset must be 0; full word.
- Error: a misaligned offset, an unknown sub-type, or ram_r_addr[29:ADDR_W] != 0 gives ld_err=1 and ld_val=0. ld_valid is still 1 and ram_r_data still shows the indexed word (low ADDR_W bits).
- Simultaneous read and write to different words: both proceed independently.
- Simultaneous read and write to the same word in one cycle: result is governed by the optional feature below.
- Read of a word written in the previous cycle returns the new data.

Optional Feature:
- Macro: DMEM_RESP_BYPASS_EN.
- Defined: a same-cycle same-address read returns the merged word. Enabled lanes come from ram_w_data; other lanes come from the array.
- Undefined: a same-cycle same-address read returns the old array word (read-before-write). The write still lands.

Decomposition:
- Shared defines header (alongside the existing insn-type codes) holds the load sub-type codes: L_B=0, L_H=1, L_W=2, L_BU=4, L_HU=5.
- One sub-module, dmem_load_align: combinational extract/extend/error from (word, sub_type, offset, oob). It is reusable by the bypass path and testable standalone.
- FSM state encodings are local parameters.

Test Plan:
- Clear: assert rst 1 cycle with ADDR_W=4 and INIT_VAL=32'hA5A5A5A5.
  - Expected: init_done rises exactly 16 cycles after rst drops.
  - Expected: L_W from word 7 then returns 32'hA5A5A5A5.
  - Expected: a write issued during clear has no effect.
- Byte-enable write/read:
  - Setup: write 32'h11223344 with byte_en 1111 to word 3, then 32'h0000AB00 with byte_en 0010.
  - Stimulus: L_W on word 3.
  - Expected: next cycle ld_val=32'h1122AB44, ld_valid=1.
- Extension: word 32'h80FF7F01.
  - L_B offset 1 → 32'h0000007F.
  - L_B offset 2 → 32'hFFFFFFFF.
  - L_BU offset 2 → 32'h000000FF.
  - L_H offset 2 → 32'hFFFF80FF.
  - L_HU offset 2 → 32'h000080FF.
- Errors:
  - L_H offset 1 → ld_err=1, ld_val=0.
  - L_W offset 2 → ld_err=1.
  - L_W on address 2**ADDR_W → ld_err=1.
  - Sub-type 7 → ld_err=1.
- Same-address collision: word 5 = 0, write 32'hDEADBEEF with byte_en 1111 while reading word 5 in the same cycle.
  - With DMEM_RESP_BYPASS_EN: read returns 32'hDEADBEEF.
  - Without it: read returns 0, and the following read returns 32'hDEADBEEF.
- Reset mid-run: issue a read, assert rst on the next edge.
  - Expected: ld_valid=0, init_done=0, full clear repeats.
  - Expected: previously written data reads as INIT_VAL.
